fixed_multiplier: RTL

Sequential sign-magnitude fixed-point multiplier for the reservoir datapath. Format is N bits: bit N-1 is sign, bits N-2:0 are magnitude, with Q fractional bits. It is the multiplicative counterpart of the fixed-point divider and uses the same start/complete handshake, so the two can sit side by side in the neuron update pipeline. It uses shift-add over N-1 cycles, truncates the result to Q fractional bits, and saturates on overflow.

---
 rtl/fixed_multiplier.sv | 100 ++++++++++
 1 files changed

// File: rtl/fixed_multiplier.sv
// Sequential sign-magnitude fixed-point multiplier (shift-add, N-1 cycles).
// Truncates to Q fractional bits and saturates the magnitude on overflow.
module fixed_multiplier #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         iClk,
  input  logic         iReset,
  input  logic         iStart,
  input  logic [N-1:0] iMultiplicand,
  input  logic [N-1:0] iMultiplier,
  output logic [N-1:0] oProduct,
  output logic         oOverflow,
  output logic         oComplete
);

  localparam int AW = 2 * N - 2;
  localparam int CW = $clog2(N);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_next;

  logic [AW-1:0] mag_a;
  logic [N-2:0]  mag_b;
  logic [AW-1:0] acc;
  logic [CW-1:0] count;
  logic          sign;
  logic [N-1:0]  product_r;
  logic          overflow_r;

  logic [AW-1:0] acc_sum;
  logic [AW-1:0] scaled;
  logic          ovf;
  logic [N-2:0]  mag_res;
  logic          last;

  always_ff @(posedge iClk) begin
    if (iReset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    last       = (count == '0);
    // Final bit is folded into the result on the same edge that returns to IDLE
    acc_sum    = acc + (mag_b[0] ? mag_a : '0);
    scaled     = acc_sum >> Q;
    ovf        = |scaled[AW-1:N-1];
    mag_res    = ovf ? '1 : scaled[N-2:0];
    oComplete  = (state == IDLE);
    case (state)
      IDLE:    if (iStart) state_next = RUN;
      RUN:     if (last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      mag_a      <= '0;
      mag_b      <= '0;
      acc        <= '0;
      count      <= '0;
      sign       <= 1'b0;
      product_r  <= '0;
      overflow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            mag_a <= {{(N-1){1'b0}}, iMultiplicand[N-2:0]};
            mag_b <= iMultiplier[N-2:0];
            acc   <= '0;
            count <= CW'(N - 2);
            sign  <= iMultiplicand[N-1] ^ iMultiplier[N-1];
          end
        end
        RUN: begin
          acc   <= acc_sum;
          mag_a <= mag_a << 1;
          mag_b <= mag_b >> 1;
          count <= count - 1'b1;
          if (last) begin
            product_r  <= {sign & (|mag_res), mag_res};
            overflow_r <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign oProduct  = product_r;
  assign oOverflow = overflow_r;

endmodule
